// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN datapath: fixed-point width derivation,
// address-width helper and the feeder control-state encoding.
package rnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } fsm_state_t;

    // Ceiling log2, never less than 1 so a single-entry memory still has an address bit.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

endpackage

// File: rtl/vec_pingpong_buf.sv
// Two-bank input-vector buffer: one bank fills from the upstream stream while
// the other is read by column address; banks are recycled on release.
module vec_pingpong_buf #(
    parameter int NCOL          = 4,
    parameter int BITWIDTH      = 18,
    parameter int ADDR_BITWIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [BITWIDTH-1:0] i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_release,
    output logic                       o_rd_full,
    input  logic [ADDR_BITWIDTH-1:0]   i_rd_addr,
    output logic signed [BITWIDTH-1:0] o_rd_data
);

    logic signed [BITWIDTH-1:0] r_buf [2][NCOL];
    logic [1:0]                 r_full;
    logic                       r_wr_bank;
    logic                       r_rd_bank;
    logic [ADDR_BITWIDTH-1:0]   r_wr_cnt;
    logic                       r_live;
    logic signed [BITWIDTH-1:0] r_rd_data;

    logic w_push;
    logic w_last;
    logic w_rd_ok;

    // r_live keeps in_ready low for the whole reset and rises the cycle after release.
    assign o_ready   = r_live && !r_full[r_wr_bank];
    assign w_push    = i_valid && o_ready;
    assign w_last    = (r_wr_cnt == ADDR_BITWIDTH'(NCOL - 1));
    assign w_rd_ok   = ({1'b0, i_rd_addr} < (ADDR_BITWIDTH + 1)'(NCOL));
    assign o_rd_full = r_full[r_rd_bank];
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_live    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                if (w_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= !r_wr_bank;
                    r_wr_cnt          <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            // A filling bank is never the bank being released, so both updates coexist.
            if (i_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= !r_rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr_bank][r_wr_cnt] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset)        r_rd_data <= '0;
        else if (w_rd_ok) r_rd_data <= r_buf[r_rd_bank][i_rd_addr];
        else              r_rd_data <= '0;
    end

endmodule

// File: rtl/dot_prod_feeder.sv
// Operand feeder for the dot-product engine: weight column memory, ping-pong
// input buffer and run control. Define FEEDER_ERR_CNT_EN to build the error counter.
module dot_prod_feeder
    import rnn_pkg::*;
#(
    parameter int  NROW          = 16,
    parameter int  NCOL          = 4,
    parameter int  QN            = 6,
    parameter int  QM            = 11,
    localparam int BITWIDTH      = calc_bitwidth(QN, QM),
    localparam int ADDR_BITWIDTH = log2(NCOL)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [BITWIDTH-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         w_wr_en,
    input  logic [ADDR_BITWIDTH-1:0]     w_wr_addr,
    input  logic [BITWIDTH*NROW-1:0]     w_wr_data,
    input  logic [ADDR_BITWIDTH-1:0]     rd_addr,
    output logic [BITWIDTH*NROW-1:0]     rd_weight_row,
    output logic signed [BITWIDTH-1:0]   rd_input,
    output logic                         eng_start,
    input  logic                         eng_done,
    output logic                         busy,
    output logic [7:0]                   err_cnt
);

    localparam int ROW_W = BITWIDTH * NROW;

    fsm_state_t       r_state;
    fsm_state_t       w_state_nxt;
    logic [ROW_W-1:0] r_wmem [NCOL];
    logic [ROW_W-1:0] r_rd_weight_row;

    logic w_release;
    logic w_bank_full;
    logic w_wr_addr_ok;
    logic w_wr_ok;
    logic w_rd_addr_ok;

    vec_pingpong_buf #(
        .NCOL          (NCOL),
        .BITWIDTH      (BITWIDTH),
        .ADDR_BITWIDTH (ADDR_BITWIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_data    (in_data),
        .i_valid   (in_valid),
        .o_ready   (in_ready),
        .i_release (w_release),
        .o_rd_full (w_bank_full),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_input)
    );

    assign w_wr_addr_ok  = ({1'b0, w_wr_addr} < (ADDR_BITWIDTH + 1)'(NCOL));
    assign w_rd_addr_ok  = ({1'b0, rd_addr} < (ADDR_BITWIDTH + 1)'(NCOL));
    assign w_wr_ok       = w_wr_en && (r_state == IDLE) && w_wr_addr_ok;
    assign eng_start     = (r_state == START);
    assign busy          = (r_state != IDLE);
    assign rd_weight_row = r_rd_weight_row;

    // Weights only change between runs so the engine never sees a torn column.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_wmem[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)             r_rd_weight_row <= '0;
        else if (w_rd_addr_ok) r_rd_weight_row <= r_wmem[rd_addr];
        else                   r_rd_weight_row <= '0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        case (r_state)
            IDLE:  if (w_bank_full) w_state_nxt = START;
            START: w_state_nxt = RUN;
            RUN: begin
                if (eng_done) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef FEEDER_ERR_CNT_EN
    localparam int STALL_W = $clog2(NCOL + 2);

    logic [7:0]         r_err_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_stall;
    logic               w_err_evt;

    assign w_stall   = in_valid && !in_ready;
    // The stall counter parks at NCOL+1, so each stall episode reports once.
    assign w_err_evt = (w_wr_en && !w_wr_ok)
                    || (eng_done && (r_state != RUN))
                    || (w_stall && (r_stall_cnt == STALL_W'(NCOL)));
    assign err_cnt   = r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (!w_stall)                             r_stall_cnt <= '0;
            else if (r_stall_cnt <= STALL_W'(NCOL))   r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_err_evt && (r_err_cnt != 8'hFF))    r_err_cnt   <= r_err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed bench for dot_prod_feeder: a 4-column instance for the main scenarios
// and a 5-column instance for address-range and wrap behaviour.
module tb_dot_prod_feeder;

    localparam int NROW = 16;
    localparam int BW   = 18;
    localparam int RW   = BW * NROW;
    localparam int AW   = 2;
    localparam int AW5  = 3;
`ifdef FEEDER_ERR_CNT_EN
    localparam logic [7:0] ERR_ON = 8'd1;
`else
    localparam logic [7:0] ERR_ON = 8'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic                 reset;
    logic signed [BW-1:0] in_data, in_data5;
    logic                 in_valid, in_valid5, in_ready, in_ready5;
    logic                 w_wr_en, w_wr_en5;
    logic [AW-1:0]        w_wr_addr, rd_addr;
    logic [AW5-1:0]       w_wr_addr5, rd_addr5;
    logic [RW-1:0]        w_wr_data, w_wr_data5, rd_weight_row, rd_weight_row5;
    logic signed [BW-1:0] rd_input, rd_input5;
    logic                 eng_start, eng_start5, eng_done, eng_done5, busy, busy5;
    logic [7:0]           err_cnt, err_cnt5;

    dot_prod_feeder dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .rd_addr(rd_addr),
        .rd_weight_row(rd_weight_row), .rd_input(rd_input), .eng_start(eng_start),
        .eng_done(eng_done), .busy(busy), .err_cnt(err_cnt)
    );

    dot_prod_feeder #(.NCOL(5)) dut5 (
        .clk(clk), .reset(reset), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .w_wr_en(w_wr_en5), .w_wr_addr(w_wr_addr5), .w_wr_data(w_wr_data5), .rd_addr(rd_addr5),
        .rd_weight_row(rd_weight_row5), .rd_input(rd_input5), .eng_start(eng_start5),
        .eng_done(eng_done5), .busy(busy5), .err_cnt(err_cnt5)
    );

    function automatic logic [RW-1:0] col_word(input int c);
        logic [RW-1:0] w;
        w = '0;
        for (int i = 0; i < NROW; i++) w[i*BW +: BW] = BW'(c * 16 + i);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_valid5 = 1'b0; in_data = '0; in_data5 = '0;
        w_wr_en = 1'b0; w_wr_en5 = 1'b0; w_wr_addr = '0; w_wr_addr5 = '0;
        w_wr_data = '0; w_wr_data5 = '0; rd_addr = '0; rd_addr5 = '0;
        eng_done = 1'b0; eng_done5 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Offers one element and holds it until accepted; acc is the transfer edge count.
    task automatic push(input logic signed [BW-1:0] d, output int acc, output int waited);
        in_data = d; in_valid = 1'b1; waited = 0;
        while (!in_ready && waited < 200) begin tick(); waited++; end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
        end
        tick();
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic push5(input logic signed [BW-1:0] d);
        int n;
        in_data5 = d; in_valid5 = 1'b1; n = 0;
        while (!in_ready5 && n < 200) begin tick(); n++; end
        if (!in_ready5) begin
            vectors++; miscompares++;
            $display("FAIL push5_timeout in_ready=%0b required 1", in_ready5);
        end
        tick();
        in_valid5 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_valid5 = 1'b0; w_wr_en = 1'b0; w_wr_en5 = 1'b0;
        eng_done = 1'b0; eng_done5 = 1'b0; rd_addr = '0; rd_addr5 = '0;
        in_data = '0; in_data5 = '0; w_wr_addr = '0; w_wr_addr5 = '0;
        w_wr_data = '0; w_wr_data5 = '0;
        tick(); tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL rst_eng_start got=%0b exp=0", eng_start); end
        vectors++; if (rd_input !== '0) begin miscompares++; $display("FAIL rst_rd_input got=%0d exp=0", rd_input); end
        vectors++; if (rd_weight_row !== '0) begin miscompares++; $display("FAIL rst_rd_weight_row got=%h exp=0", rd_weight_row); end
        vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
        reset = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_stream_read();
        logic signed [BW-1:0] v [4];
        int acc, waited;
        v = '{18'sd2048, 18'sd4096, -18'sd2048, 18'sd1024};
        for (int c = 0; c < 4; c++) begin
            w_wr_en = 1'b1; w_wr_addr = AW'(c); w_wr_data = col_word(c);
            tick();
        end
        w_wr_en = 1'b0;
        for (int a = 0; a < 4; a++) push(v[a], acc, waited);
        vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL sr_start_early got=%0b exp=0", eng_start); end
        tick();
        vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL sr_start got=%0b exp=1", eng_start); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sr_busy got=%0b exp=1", busy); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            tick();
            if (a == 0) begin
                vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL sr_start_width got=%0b exp=0", eng_start); end
            end
            vectors++; if (rd_input !== v[a]) begin miscompares++; $display("FAIL sr_rd_input[%0d] got=%0d exp=%0d", a, rd_input, v[a]); end
            vectors++; if (rd_weight_row !== col_word(a)) begin miscompares++; $display("FAIL sr_rd_weight[%0d] got=%h exp=%h", a, rd_weight_row, col_word(a)); end
        end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sr_in_ready got=%0b exp=1", in_ready); end
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sr_done_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic signed [BW-1:0] bv [3][4];
        int starts, acc_c, done0_cyc, stall_c;
        bv[0] = '{18'sd100, 18'sd200, 18'sd300, 18'sd400};
        bv[1] = '{-18'sd1, -18'sd2, -18'sd3, -18'sd4};
        bv[2] = '{18'sd8191, -18'sd8192, 18'sd0, 18'sd1};
        starts = 0; acc_c = 0; done0_cyc = 0; stall_c = 0;
        fork
            begin
                int acc, waited;
                for (int k = 0; k < 3; k++)
                    for (int a = 0; a < 4; a++) begin
                        push(bv[k][a], acc, waited);
                        if (k == 2 && a == 0) begin acc_c = acc; stall_c = waited; end
                    end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    int n;
                    n = 0;
                    while (!eng_start && n < 200) begin tick(); n++; end
                    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL b2b_start%0d got=%0b exp=1", k, eng_start); end
                    if (eng_start) starts++;
                    for (int a = 0; a < 4; a++) begin
                        rd_addr = AW'(a);
                        tick();
                        vectors++; if (rd_input !== bv[k][a]) begin miscompares++; $display("FAIL b2b_rd_input[%0d][%0d] got=%0d exp=%0d", k, a, rd_input, bv[k][a]); end
                    end
                    repeat (6) tick();
                    eng_done = 1'b1;
                    tick();
                    eng_done = 1'b0;
                    if (k == 0) done0_cyc = cyc;
                end
            end
        join
        vectors++; if (starts !== 3) begin miscompares++; $display("FAIL b2b_start_count got=%0d exp=3", starts); end
        vectors++; if (!(stall_c > 0)) begin miscompares++; $display("FAIL b2b_stall got=%0d exp>0", stall_c); end
        vectors++; if (!(acc_c > done0_cyc)) begin miscompares++; $display("FAIL b2b_vec3_after_done got=%0d exp>%0d", acc_c, done0_cyc); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_busy_write();
        int acc, waited;
        do_reset();
        for (int a = 0; a < 4; a++) push(BW'(a + 1), acc, waited);
        tick(); tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bw_busy got=%0b exp=1", busy); end
        w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = '1;
        tick();
        w_wr_en = 1'b0;
        vectors++; if (err_cnt !== ERR_ON) begin miscompares++; $display("FAIL bw_err_cnt got=%0d exp=%0d", err_cnt, ERR_ON); end
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        rd_addr = '0;
        tick();
        vectors++; if (rd_weight_row !== col_word(0)) begin miscompares++; $display("FAIL bw_readback got=%h exp=%h", rd_weight_row, col_word(0)); end
    endtask

    task automatic test_done_idle();
        int acc, waited;
        do_reset();
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL di_busy got=%0b exp=0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL di_in_ready got=%0b exp=1", in_ready); end
        vectors++; if (err_cnt !== ERR_ON) begin miscompares++; $display("FAIL di_err_cnt got=%0d exp=%0d", err_cnt, ERR_ON); end
        tick();
        vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL di_no_start got=%0b exp=0", eng_start); end
        for (int a = 0; a < 4; a++) push(BW'(50 + a), acc, waited);
        tick();
        vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL di_start_bank0 got=%0b exp=1", eng_start); end
        rd_addr = AW'(3);
        tick();
        vectors++; if (rd_input !== 18'sd53) begin miscompares++; $display("FAIL di_rd_input got=%0d exp=53", rd_input); end
        eng_done = 1'b1; tick(); eng_done = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int acc, waited;
        do_reset();
        for (int a = 0; a < 8; a++) push(BW'(a + 1), acc, waited);
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rm_busy_before got=%0b exp=1", busy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rm_full_in_ready got=%0b exp=0", in_ready); end
        reset = 1'b1; tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy_after got=%0b exp=0", busy); end
        reset = 1'b0; tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rm_in_ready got=%0b exp=1", in_ready); end
        for (int a = 0; a < 3; a++) push(BW'(a + 20), acc, waited);
        tick(); tick();
        vectors++; if (eng_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rm_no_start got=%0b/%0b exp=0/0", eng_start, busy); end
        push(BW'(23), acc, waited);
        tick();
        vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL rm_start got=%0b exp=1", eng_start); end
        tick();
        eng_done = 1'b1; tick(); eng_done = 1'b0;
    endtask

    task automatic test_ncol5();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            w_wr_en5 = 1'b1; w_wr_addr5 = AW5'(c); w_wr_data5 = col_word(c);
            tick();
        end
        w_wr_en5 = 1'b1; w_wr_addr5 = AW5'(5); w_wr_data5 = '1;
        tick();
        w_wr_en5 = 1'b0;
        vectors++; if (err_cnt5 !== ERR_ON) begin miscompares++; $display("FAIL n5_err_cnt got=%0d exp=%0d", err_cnt5, ERR_ON); end
        for (int a = 0; a < 5; a++) push5(BW'(11 + a));
        vectors++; if (in_ready5 !== 1'b1) begin miscompares++; $display("FAIL n5_in_ready got=%0b exp=1", in_ready5); end
        for (int a = 0; a < 5; a++) push5(BW'(21 + a));
        for (int a = 0; a < 8; a++) begin
            rd_addr5 = AW5'(a);
            tick();
            if (a < 5) begin
                vectors++; if (rd_input5 !== BW'(11 + a)) begin miscompares++; $display("FAIL n5_rd_input[%0d] got=%0d exp=%0d", a, rd_input5, 11 + a); end
                vectors++; if (rd_weight_row5 !== col_word(a)) begin miscompares++; $display("FAIL n5_rd_weight[%0d] got=%h exp=%h", a, rd_weight_row5, col_word(a)); end
            end else begin
                vectors++; if (rd_input5 !== '0) begin miscompares++; $display("FAIL n5_oor_input[%0d] got=%0d exp=0", a, rd_input5); end
                vectors++; if (rd_weight_row5 !== '0) begin miscompares++; $display("FAIL n5_oor_weight[%0d] got=%h exp=0", a, rd_weight_row5); end
            end
        end
        eng_done5 = 1'b1; tick(); eng_done5 = 1'b0;
        for (int a = 0; a < 5; a++) begin
            rd_addr5 = AW5'(a);
            tick();
            vectors++; if (rd_input5 !== BW'(21 + a)) begin miscompares++; $display("FAIL n5_wrap_input[%0d] got=%0d exp=%0d", a, rd_input5, 21 + a); end
        end
        vectors++; if (busy5 !== 1'b1) begin miscompares++; $display("FAIL n5_second_run got=%0b exp=1", busy5); end
    endtask

    initial begin
        test_reset();
        test_stream_read();
        test_back_to_back();
        test_busy_write();
        test_done_idle();
        test_reset_mid_run();
        test_ncol5();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "bench did not complete");
    end

endmodule
